// File: rtl/adc_frame_pkg.sv
// Shared types and widths for the ADC frame writer.
package adc_frame_pkg;

    localparam int unsigned CH_W   = 3;
    localparam int unsigned SNAP_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 1 + SNAP_W + CH_W;

    typedef enum logic [1:0] {SYNC, FILL, STALL} wr_state_t;

    // RAM word address: {bank, snapshot, channel}
    typedef struct packed {
        logic              bank;
        logic [SNAP_W-1:0] snap;
        logic [CH_W-1:0]   chan;
    } ram_addr_t;

endpackage

// File: rtl/bank_tracker.sv
// Tracks which ping-pong banks are full, in what order they filled, and
// frees the oldest one on a reader release.
module bank_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic       set_bank,
    input  logic       rel_req,
    output logic [1:0] bank_full,
    output logic [1:0] full_post,
    output logic       bank_ready,
    output logic       ready_bank
);

    logic [1:0] full_q;
    logic       first_q;
    logic       rel_ok;
    logic [1:0] set_mask;

    // Oldest full bank; with both full, the one recorded as filling first.
    always_comb begin
        bank_full  = full_q;
        bank_ready = |full_q;
        ready_bank = (&full_q) ? first_q : full_q[1];
        rel_ok     = rel_req & (|full_q);
        full_post  = full_q & ~{rel_ok & ready_bank, rel_ok & ~ready_bank};
        set_mask   = set_en ? {set_bank, ~set_bank} : 2'b00;
    end

    // Release clears before the set lands, so both can happen in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 2'b00;
            first_q <= 1'b0;
        end else begin
            full_q <= full_post | set_mask;
            if (set_en) begin
                first_q <= full_post[~set_bank] ? ~set_bank : set_bank;
            end
        end
    end

endmodule

// File: rtl/adc_frame_writer.sv
// Writes per-channel ADC samples into the sample RAM as interleaved
// snapshots, ping-ponging between two banks handed off to a reader.
module adc_frame_writer #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CH_W   = adc_frame_pkg::CH_W,
    parameter int unsigned SNAP_W = adc_frame_pkg::SNAP_W,
    parameter int unsigned DATA_W = adc_frame_pkg::DATA_W,
    localparam int unsigned ADDR_W = 1 + SNAP_W + CH_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [CH_W-1:0]   sample_chan,
    input  logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              bank_ready,
    output logic              ready_bank,
    input  logic              bank_release,
    output logic              overflow,
    output logic              sync_err
);

    import adc_frame_pkg::wr_state_t;
    import adc_frame_pkg::ram_addr_t;
    import adc_frame_pkg::SYNC;
    import adc_frame_pkg::FILL;
    import adc_frame_pkg::STALL;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    wr_state_t         state_q;
    logic [CH_W-1:0]   exp_ch_q;
    logic [SNAP_W-1:0] snap_q;
    logic              wb_q;
    logic [1:0]        bank_full;
    logic [1:0]        full_post;
    logic              wr_ok;
    logic              complete;
    ram_addr_t         wr_addr;

    // Decide whether the current sample is written and whether it closes a bank.
    always_comb begin
        wr_ok = 1'b0;
        if (enable && sample_valid) begin
            case (state_q)
                SYNC:    wr_ok = (sample_chan == '0) && !bank_full[wb_q];
                FILL:    wr_ok = (sample_chan == exp_ch_q);
                default: wr_ok = 1'b0;
            endcase
        end
        complete     = wr_ok && (sample_chan == CH_LAST) && (&snap_q);
        wr_addr.bank = wb_q;
        wr_addr.snap = snap_q;
        wr_addr.chan = sample_chan;
    end

    bank_tracker u_bank_tracker (
        .clk        (clk),
        .reset      (reset),
        .set_en     (complete),
        .set_bank   (wb_q),
        .rel_req    (bank_release),
        .bank_full  (bank_full),
        .full_post  (full_post),
        .bank_ready (bank_ready),
        .ready_bank (ready_bank)
    );

    // Capture FSM, snapshot counters and registered RAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SYNC;
            exp_ch_q <= '0;
            snap_q   <= '0;
            wb_q     <= 1'b0;
            ram_wren <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            ram_wren <= 1'b0;
            if (wr_ok) begin
                ram_wren <= 1'b1;
                ram_addr <= wr_addr;
                ram_data <= sample_data;
            end
            if (!enable) begin
                // Snap and wb hold, so a partial snapshot is rewritten on resume.
                state_q  <= SYNC;
                exp_ch_q <= '0;
            end else begin
                case (state_q)
                    SYNC: begin
                        if (wr_ok) begin
                            exp_ch_q <= CH_W'(1);
                            state_q  <= FILL;
                        end
                    end
                    FILL: begin
                        if (sample_valid) begin
                            if (wr_ok) begin
                                if (sample_chan == CH_LAST) begin
                                    exp_ch_q <= '0;
                                    snap_q   <= snap_q + 1'b1;
                                    if (&snap_q) begin
                                        wb_q <= ~wb_q;
                                        // Post-release flags: a same-cycle release avoids STALL.
                                        if (full_post[~wb_q]) begin
                                            state_q <= STALL;
                                        end
                                    end
                                end else begin
                                    exp_ch_q <= exp_ch_q + 1'b1;
                                end
                            end else begin
                                sync_err <= 1'b1;
                                exp_ch_q <= '0;
                                state_q  <= SYNC;
                            end
                        end
                    end
                    STALL: begin
                        if (sample_valid) begin
                            overflow <= 1'b1;
                        end
                        if (!bank_full[wb_q]) begin
                            state_q <= SYNC;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

endmodule
